icache_fetch_buffer: RTL
========================

Name: icache_fetch_buffer

Overview:
- Direct-mapped instruction cache between the fetcher (PC requests) and the memory controller (word-by-word instruction refill).
- On a hit, returns the 32-bit instruction one cycle after the request.
- On a miss, drives the memory controller's fetch handshake (enable / address / per-word finish / end) to fill one line, then answers the request.
- A flush from the commit/branch logic cancels any refill in flight.

Parameters:
- LINE_WORDS, 4, instructions per line; power of 2; equals the memory controller's per-request instruction count.
- NUM_LINES, 16, number of lines; power of 2.
- ADDR_W, 32, address width.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset, asynchronous, active-high.
- rdy_in  in  1  global enable; when 0 all state freezes.
- req_valid_in  in  1  fetcher requests the instruction at pc_in.
- pc_in  in  ADDR_W  word-aligned fetch address.
- ready_out  out  1  block can accept a request this cycle.
- inst_valid_out  out  1  one-cycle pulse: inst_out is valid.
- inst_out  out  32  instruction for the accepted pc.
- flush_in  in  1  discard the pending request and abort any refill.
- enable_to_mem  out  1  fetch request to the memory controller.
- address_to_mem  out  ADDR_W  line base address.
- reset_to_mem  out  1  one-cycle abort pulse to the memory controller.
- inst_from_mem  in  32  refill word.
- one_inst_finish_from_mem  in  1  inst_from_mem valid this cycle.
- end_from_mem  in  1  memory controller has finished the line.

Behaviour:
- Address split: offset = pc[log2(LINE_WORDS)+1:2]; index = next log2(NUM_LINES) bits; tag = remaining upper bits. pc[1:0] is ignored.
- Storage per line: valid bit, tag, LINE_WORDS x 32 data.
- Reset (asynchronous, rst_in=1):
  - all valid bits cleared; state=IDLE.
  - ready_out=0, inst_valid_out=0, inst_out=0, enable_to_mem=0, address_to_mem=0, reset_to_mem=0, refill word counter=0.
  - A request or refill in progress at reset is dropped.
  - First cycle after reset release: ready_out=1.
- rdy_in=0: no state, counter, array or output changes. Memory-side pulses arriving in that cycle are ignored.
- States: IDLE, REFILL, RESP.
- IDLE (ready_out=1):
  - req_valid_in=1 with valid and tag match at index: inst_valid_out=1 and inst_out=word next cycle (latency 1); stay IDLE. Back-to-back hits give 1 result per cycle.
  - Miss: latch pc; next cycle enable_to_mem=1, address_to_mem=pc with offset and [1:0] zeroed, counter=0; go REFILL; ready_out=0.
- REFILL:
  - enable_to_mem held at 1 and address_to_mem held constant.
  - Each one_inst_finish_from_mem=1 writes inst_from_mem to word[counter], then counter+1.
  - Pulses after counter==LINE_WORDS are ignored.
  - end_from_mem=1 or counter reaching LINE_WORDS (whichever comes first): write tag and set valid (this overwrites the old line at that index); enable_to_mem=0 next cycle; go RESP.
  - end_from_mem arriving with counter<LINE_WORDS still completes the line; words not received keep their stale contents. The memory controller guarantees this does not happen.
- RESP: inst_valid_out=1 with the latched pc's word for one cycle; go IDLE.
- flush_in=1 has highest priority, in any state:
  - Next cycle: inst_valid_out=0 and state=IDLE.
  - A req_valid_in in the same cycle is ignored.
  - From REFILL: reset_to_mem=1 for exactly one cycle, enable_to_mem=0, the line's valid bit is not set, and the partially written data is don't-care.
  - From RESP: the response is suppressed.
- Request during ready_out=0: ignored. The fetcher holds it and re-presents it later.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- Defined:
  - Adds outputs hit_cnt_out [31:0] and miss_cnt_out [31:0], both reset to 0.
  - Counter +1 per accepted IDLE request (hit or miss); flushed requests are not counted; wrap at 2^32.
  - Frozen while rdy_in=0.
- Undefined: the ports and counters are absent; functionality is identical.

Decomposition:
- Shared constants package/header:
  - ADDR_TYPE, INST_TYPE widths; TRUE/FALSE; ADDR_RESET and INST_RESET values.
  - Instruction-count-per-request constant, shared with the memory controller so that LINE_WORDS matches it.
  - State encodings IDLE/REFILL/RESP.
- One sub-module, icache_line_array:
  - valid/tag/data storage.
  - Read port indexed by pc.
  - Word write port for refill data.
  - Separate tag/valid commit port.
  - Asynchronous valid clear on reset.

Test Plan:
- Cold miss at pc=0x00000108: enable_to_mem=1 with address_to_mem=0x00000100; feed 4 finish pulses with 0x11,0x22,0x33,0x44 then end -> inst_valid_out pulse with inst_out=0x33 (offset 2); ready_out returns to 1.
- Hit after refill: requests 0x100, 0x104, 0x10C on consecutive cycles -> 0x11, 0x22, 0x44 each 1 cycle later, enable_to_mem stays 0.
- Conflict: request 0x500 (same index, different tag) -> refill at 0x500; then request 0x100 -> miss again and a new refill.
- Flush after the 2nd finish pulse of a refill -> reset_to_mem pulses 1 cycle, no inst_valid_out; re-request of the same pc -> full refill from word 0.
- rdy_in=0 for 3 cycles mid-refill with finish pulses presented -> counter and outputs unchanged; completion proceeds correctly once rdy_in=1.
- With ICACHE_PERF_EN defined: sequence miss, hit, hit, flushed request -> hit_cnt_out=2, miss_cnt_out=1.

Source files
------------

// File: rtl/icache_fetch_buffer_pkg.sv
// Shared constants and state encodings for the instruction cache fetch buffer.
// The per-request instruction count is shared with the memory controller.
package icache_fetch_buffer_pkg;

  localparam int ADDR_TYPE    = 32;
  localparam int INST_TYPE    = 32;
  localparam int INST_PER_REQ = 4;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [ADDR_TYPE-1:0] ADDR_RESET = '0;
  localparam logic [INST_TYPE-1:0] INST_RESET = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/icache_line_array.sv
// Direct-mapped valid/tag/data storage addressed by word address (pc[ADDR_W-1:2]).
// Combinational read with tag compare, per-word refill write, separate tag/valid commit.
module icache_line_array
  import icache_fetch_buffer_pkg::*;
#(
  parameter int LINE_WORDS = INST_PER_REQ,
  parameter int NUM_LINES  = 16,
  parameter int ADDR_W     = ADDR_TYPE,
  localparam int OFF_W     = $clog2(LINE_WORDS),
  localparam int IDX_W     = $clog2(NUM_LINES),
  localparam int WA_W      = ADDR_W - 2,
  localparam int TAG_W     = WA_W - OFF_W - IDX_W
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [WA_W-1:0]      rd_addr,
  output logic                 rd_hit,
  output logic [INST_TYPE-1:0] rd_word,
  input  logic                 word_we,
  input  logic [WA_W-1:0]      wr_addr,
  input  logic [INST_TYPE-1:0] wr_data,
  input  logic                 commit_en
);

  logic [INST_TYPE-1:0] data_mem [NUM_LINES*LINE_WORDS];
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;

  assign rd_idx  = rd_addr[OFF_W +: IDX_W];
  assign rd_tag  = rd_addr[WA_W-1 -: TAG_W];
  assign wr_idx  = wr_addr[OFF_W +: IDX_W];
  assign wr_tag  = wr_addr[WA_W-1 -: TAG_W];
  assign rd_hit  = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_word = data_mem[rd_addr[OFF_W+IDX_W-1:0]];

  // Only the valid bits need a reset; tag and data are qualified by them.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (commit_en) begin
      valid_q[wr_idx] <= TRUE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (word_we) begin
      data_mem[wr_addr[OFF_W+IDX_W-1:0]] <= wr_data;
    end
    if (commit_en) begin
      tag_mem[wr_idx] <= wr_tag;
    end
  end

endmodule

// File: rtl/icache_fetch_buffer.sv
// Direct-mapped instruction cache: 1-cycle hits, line refill from the memory controller.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module icache_fetch_buffer
  import icache_fetch_buffer_pkg::*;
#(
  parameter int LINE_WORDS = INST_PER_REQ,
  parameter int NUM_LINES  = 16,
  parameter int ADDR_W     = ADDR_TYPE
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 req_valid_in,
  input  logic [ADDR_W-1:0]    pc_in,
  output logic                 ready_out,
  output logic                 inst_valid_out,
  output logic [INST_TYPE-1:0] inst_out,
  input  logic                 flush_in,
  output logic                 enable_to_mem,
  output logic [ADDR_W-1:0]    address_to_mem,
  output logic                 reset_to_mem,
  input  logic [INST_TYPE-1:0] inst_from_mem,
  input  logic                 one_inst_finish_from_mem,
  input  logic                 end_from_mem,
  output logic [1:0]           state_dbg
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]          hit_cnt_out,
  output logic [31:0]          miss_cnt_out
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int CNT_W = OFF_W + 1;
  localparam int WA_W  = ADDR_W - 2;

  // Handshake: a request is taken only when req_valid_in && ready_out && rdy_in && !flush_in
  // at a clock edge; otherwise the fetcher keeps presenting it.

  state_t           state, state_nxt;
  logic [WA_W-1:0]  pc_q;
  logic [CNT_W-1:0] cnt;
  logic [WA_W-1:0]  rd_addr, wr_addr;
  logic             rd_hit;
  logic [INST_TYPE-1:0] rd_word;
  logic accept, hit_acc, miss_acc, fin_ok, line_done;
  logic word_we, commit, abort, resp_fire;
  logic unused_pc_bits;

  assign unused_pc_bits = ^pc_in[1:0];
  assign state_dbg      = state;

  icache_line_array #(
    .LINE_WORDS(LINE_WORDS),
    .NUM_LINES (NUM_LINES),
    .ADDR_W    (ADDR_W)
  ) u_lines (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rd_addr  (rd_addr),
    .rd_hit   (rd_hit),
    .rd_word  (rd_word),
    .word_we  (word_we),
    .wr_addr  (wr_addr),
    .wr_data  (inst_from_mem),
    .commit_en(commit)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else if (rdy_in) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!flush_in && req_valid_in && !rd_hit) state_nxt = REFILL;
      end
      REFILL: begin
        if (flush_in)       state_nxt = IDLE;
        else if (line_done) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Flush outranks everything; a line completes on end_from_mem or on its last word.
  always_comb begin
    accept    = rdy_in && (state == IDLE) && req_valid_in && !flush_in;
    hit_acc   = accept && rd_hit;
    miss_acc  = accept && !rd_hit;
    fin_ok    = one_inst_finish_from_mem && (cnt < CNT_W'(LINE_WORDS));
    line_done = end_from_mem || (fin_ok && (cnt == CNT_W'(LINE_WORDS - 1)));
    word_we   = rdy_in && (state == REFILL) && !flush_in && fin_ok;
    commit    = rdy_in && (state == REFILL) && !flush_in && line_done;
    abort     = rdy_in && (state == REFILL) && flush_in;
    resp_fire = rdy_in && (state == RESP) && !flush_in;
    ready_out = (state == IDLE) && !rst_in;
    rd_addr   = (state == IDLE) ? pc_in[ADDR_W-1:2] : pc_q;
    wr_addr   = {pc_q[WA_W-1:OFF_W], cnt[OFF_W-1:0]};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      inst_valid_out <= FALSE;
      inst_out       <= INST_RESET;
      enable_to_mem  <= FALSE;
      address_to_mem <= ADDR_W'(ADDR_RESET);
      reset_to_mem   <= FALSE;
      pc_q           <= '0;
      cnt            <= '0;
    end else if (rdy_in) begin
      inst_valid_out <= hit_acc || resp_fire;
      reset_to_mem   <= abort;
      if (hit_acc || resp_fire) begin
        inst_out <= rd_word;
      end
      if (miss_acc) begin
        pc_q           <= pc_in[ADDR_W-1:2];
        address_to_mem <= {pc_in[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
        enable_to_mem  <= TRUE;
        cnt            <= '0;
      end else if (abort || commit) begin
        enable_to_mem  <= FALSE;
      end
      if (word_we) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hit_cnt_out  <= '0;
      miss_cnt_out <= '0;
    end else if (rdy_in) begin
      if (hit_acc)  hit_cnt_out  <= hit_cnt_out + 32'd1;
      if (miss_acc) miss_cnt_out <= miss_cnt_out + 32'd1;
    end
  end
`endif

endmodule
